// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the shared datapath of the multicycle MIPS-subset core
module multicycle_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_i,
  input  logic [OP_W-1:0] funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            alusrca_i,
  output logic [2:0]      alusrcb_i,
  output logic [2:0]      alucont_i,
  output logic [1:0]      pcsource_i,
  output logic            pcen_i,
  output logic            irwrite_i,
  output logic            iord_i,
  output logic            memtoreg_i,
  output logic            regdst_i,
  output logic            regwrite_i,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);
  typedef enum logic [ST_W-1:0] {
    FETCH   = ST_W'(0),
    DECODE  = ST_W'(1),
    MEMADR  = ST_W'(2),
    MEMRD   = ST_W'(3),
    MEMWR   = ST_W'(4),
    RTYPEEX = ST_W'(5),
    RTYPEWB = ST_W'(6),
    BEQEX   = ST_W'(7),
    ADDIEX  = ST_W'(8),
    ADDIWB  = ST_W'(9),
    JEX     = ST_W'(10)
  } state_t;
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] F_ADD   = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] F_SUB   = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] F_AND   = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] F_OR    = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] F_SLT   = OP_W'(6'b101010);
  state_t     state_q, state_d;
  logic [2:0] funct_alu;
  logic       funct_ok;
  assign state_o = state_q;
  // ALU operation and legality of the R-type funct field
  always_comb begin
    funct_alu = funct_i == F_SUB ? 3'b110 :
                funct_i == F_AND ? 3'b000 :
                funct_i == F_OR  ? 3'b001 :
                funct_i == F_SLT ? 3'b111 : 3'b010;
    funct_ok  = funct_i inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  end
  // state register; reset returns to FETCH and aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end
  // next state and datapath controls; reset leaves everything at default with enables low
  always_comb begin
    state_d    = FETCH;
    alusrca_i  = 1'b0;
    alusrcb_i  = 3'b000;
    alucont_i  = 3'b010;
    pcsource_i = 2'b00;
    pcen_i     = 1'b0;
    irwrite_i  = 1'b0;
    iord_i     = 1'b0;
    memtoreg_i = 1'b0;
    regdst_i   = 1'b0;
    regwrite_i = 1'b0;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    illegal_o  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          memread_o = 1'b1;
          alusrcb_i = 3'b001;
          irwrite_i = mem_ready_i;
          pcen_i    = mem_ready_i;
          state_d   = mem_ready_i ? DECODE : FETCH;
        end
        DECODE: begin
          alusrcb_i = 3'b011;
          state_d   = (op_i == OP_LW || op_i == OP_SW) ? MEMADR  :
                      (op_i == OP_R && funct_ok)       ? RTYPEEX :
                      op_i == OP_BEQ                   ? BEQEX   :
                      op_i == OP_ADDI                  ? ADDIEX  :
                      op_i == OP_J                     ? JEX     : FETCH;
          illegal_o = state_d == FETCH;
        end
        MEMADR: begin
          alusrca_i = 1'b1;
          alusrcb_i = 3'b100;
          state_d   = op_i == OP_SW ? MEMWR : MEMRD;
        end
        MEMRD: begin
          iord_i     = 1'b1;
          memread_o  = 1'b1;
          memtoreg_i = 1'b1;
          regwrite_i = mem_ready_i;
          state_d    = mem_ready_i ? FETCH : MEMRD;
        end
        MEMWR: begin
          iord_i     = 1'b1;
          memwrite_o = 1'b1;
          state_d    = mem_ready_i ? FETCH : MEMWR;
        end
        RTYPEEX: begin
          alusrca_i = 1'b1;
          alucont_i = funct_alu;
          state_d   = RTYPEWB;
        end
        RTYPEWB: begin
          regdst_i   = 1'b1;
          regwrite_i = 1'b1;
        end
        BEQEX: begin
          alusrca_i  = 1'b1;
          alucont_i  = 3'b110;
          pcsource_i = 2'b01;
          pcen_i     = zero_i;
        end
        ADDIEX: begin
          alusrca_i = 1'b1;
          alusrcb_i = 3'b100;
          state_d   = ADDIWB;
        end
        ADDIWB: regwrite_i = 1'b1;
        JEX: begin
          pcsource_i = 2'b10;
          pcen_i     = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for the multicycle control FSM
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst, zero_i, mem_ready_i;
  logic [5:0] op_i, funct_i;
  logic       alusrca_i, pcen_i, irwrite_i, iord_i, memtoreg_i, regdst_i, regwrite_i;
  logic       memread_o, memwrite_o, illegal_o;
  logic [2:0] alusrcb_i, alucont_i;
  logic [1:0] pcsource_i;
  logic [3:0] state_o;
  logic [5:0] en;
  int         n_cmp = 0;
  int         n_bad = 0;
  localparam logic [5:0] EN_NONE  = 6'b000000;
  localparam logic [5:0] EN_FETCH = 6'b110100;
  localparam logic [5:0] EN_FWAIT = 6'b000100;
  localparam logic [5:0] EN_RD    = 6'b001100;
  localparam logic [5:0] EN_WR    = 6'b000010;
  localparam logic [5:0] EN_RW    = 6'b001000;
  localparam logic [5:0] EN_PC    = 6'b100000;
  localparam logic [5:0] EN_ILL   = 6'b000001;
  multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .alusrca_i(alusrca_i), .alusrcb_i(alusrcb_i),
    .alucont_i(alucont_i), .pcsource_i(pcsource_i), .pcen_i(pcen_i),
    .irwrite_i(irwrite_i), .iord_i(iord_i), .memtoreg_i(memtoreg_i),
    .regdst_i(regdst_i), .regwrite_i(regwrite_i), .memread_o(memread_o),
    .memwrite_o(memwrite_o), .illegal_o(illegal_o), .state_o(state_o)
  );
  assign en = {pcen_i, irwrite_i, regwrite_i, memread_o, memwrite_o, illegal_o};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string tag, input logic [3:0] s, input logic [5:0] e);
    #1;
    chk({tag, ".state"}, 8'(state_o), 8'(s));
    chk({tag, ".en"}, 8'(en), 8'(e));
  endtask
  task automatic rtype(input string tag, input logic [5:0] f, input logic [2:0] alu);
    op_i = 6'b000000;
    funct_i = f;
    st({tag, ".F"}, 4'd0, EN_FETCH);
    tick;
    st({tag, ".D"}, 4'd1, EN_NONE);
    tick;
    st({tag, ".EX"}, 4'd5, EN_NONE);
    chk({tag, ".alucont"}, 8'(alucont_i), 8'(alu));
    chk({tag, ".alusrcb"}, 8'(alusrcb_i), 8'h0);
    chk({tag, ".alusrca"}, 8'(alusrca_i), 8'h1);
    tick;
    st({tag, ".WB"}, 4'd6, EN_RW);
    chk({tag, ".regdst"}, 8'(regdst_i), 8'h1);
    chk({tag, ".memtoreg"}, 8'(memtoreg_i), 8'h0);
    tick;
  endtask
  task automatic illegal(input string tag, input logic [5:0] op, input logic [5:0] f);
    op_i = op;
    funct_i = f;
    st({tag, ".F"}, 4'd0, EN_FETCH);
    tick;
    st({tag, ".D"}, 4'd1, EN_ILL);
    tick;
    st({tag, ".back"}, 4'd0, EN_FETCH);
  endtask
  initial begin
    rst = 1'b1;
    mem_ready_i = 1'b1;
    zero_i = 1'b0;
    op_i = 6'b000000;
    funct_i = 6'b000000;
    tick;
    st("rst0", 4'd0, EN_NONE);
    chk("rst0.alucont", 8'(alucont_i), 8'h2);
    tick;
    st("rst1", 4'd0, EN_NONE);
    rst = 1'b0;
    st("post", 4'd0, EN_FETCH);
    chk("post.alusrcb", 8'(alusrcb_i), 8'h1);
    op_i = 6'b100011;
    tick;
    st("lw.D", 4'd1, EN_NONE);
    chk("lw.D.alusrcb", 8'(alusrcb_i), 8'h3);
    tick;
    st("lw.A", 4'd2, EN_NONE);
    chk("lw.A.alusrcb", 8'(alusrcb_i), 8'h4);
    chk("lw.A.alusrca", 8'(alusrca_i), 8'h1);
    tick;
    st("lw.R", 4'd3, EN_RD);
    chk("lw.R.iord", 8'(iord_i), 8'h1);
    chk("lw.R.memtoreg", 8'(memtoreg_i), 8'h1);
    chk("lw.R.regdst", 8'(regdst_i), 8'h0);
    tick;
    st("lw.F", 4'd0, EN_FETCH);
    op_i = 6'b101011;
    tick;
    st("sw.D", 4'd1, EN_NONE);
    tick;
    st("sw.A", 4'd2, EN_NONE);
    tick;
    mem_ready_i = 1'b0;
    st("sw.W0", 4'd4, EN_WR);
    chk("sw.W0.iord", 8'(iord_i), 8'h1);
    for (int i = 0; i < 2; i++) begin
      tick;
      st("sw.Wn", 4'd4, EN_WR);
    end
    tick;
    mem_ready_i = 1'b1;
    st("sw.W3", 4'd4, EN_WR);
    tick;
    st("sw.F", 4'd0, EN_FETCH);
    rtype("sub", 6'b100010, 3'b110);
    rtype("add", 6'b100000, 3'b010);
    rtype("and", 6'b100100, 3'b000);
    rtype("or",  6'b100101, 3'b001);
    rtype("slt", 6'b101010, 3'b111);
    op_i = 6'b000100;
    zero_i = 1'b1;
    st("beq.F", 4'd0, EN_FETCH);
    tick;
    st("beq.D", 4'd1, EN_NONE);
    tick;
    st("beq.E1", 4'd7, EN_PC);
    chk("beq.pcsource", 8'(pcsource_i), 8'h1);
    chk("beq.alucont", 8'(alucont_i), 8'h6);
    zero_i = 1'b0;
    st("beq.E0", 4'd7, EN_NONE);
    tick;
    st("beq.F2", 4'd0, EN_FETCH);
    op_i = 6'b001000;
    tick;
    st("addi.D", 4'd1, EN_NONE);
    tick;
    st("addi.E", 4'd8, EN_NONE);
    chk("addi.alusrcb", 8'(alusrcb_i), 8'h4);
    tick;
    st("addi.WB", 4'd9, EN_RW);
    chk("addi.regdst", 8'(regdst_i), 8'h0);
    tick;
    st("j.F", 4'd0, EN_FETCH);
    op_i = 6'b000010;
    tick;
    st("j.D", 4'd1, EN_NONE);
    tick;
    st("j.E", 4'd10, EN_PC);
    chk("j.pcsource", 8'(pcsource_i), 8'h2);
    tick;
    illegal("illop", 6'b111111, 6'b000000);
    illegal("illfn", 6'b000000, 6'b000111);
    mem_ready_i = 1'b0;
    st("fwait", 4'd0, EN_FWAIT);
    tick;
    st("fwait2", 4'd0, EN_FWAIT);
    mem_ready_i = 1'b1;
    op_i = 6'b101011;
    tick;
    st("rsw.D", 4'd1, EN_NONE);
    tick;
    st("rsw.A", 4'd2, EN_NONE);
    tick;
    mem_ready_i = 1'b0;
    st("rsw.W", 4'd4, EN_WR);
    rst = 1'b1;
    st("rsw.rst", 4'd4, EN_NONE);
    chk("rsw.rst.iord", 8'(iord_i), 8'h0);
    tick;
    st("rsw.after", 4'd0, EN_NONE);
    rst = 1'b0;
    mem_ready_i = 1'b1;
    st("rsw.F", 4'd0, EN_FETCH);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
